// File: rtl/branch_hazard_unit.sv
// rtl/branch_hazard_unit.sv - ID-stage branch/load hazard detection and comparator forwarding control
module branch_hazard_unit #(
    parameter logic [5:0] BEQ_OP = 6'b000100,
    parameter int         RW     = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [5:0]    id_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          takebranch,
    output logic [1:0]    fa,
    output logic [1:0]    fb,
    output logic          stall,
    output logic          flush
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    logic [RW-1:0] ex_dst, mem_dst, wb_dst;
    logic          ex_wr, mem_wr, wb_wr;
    logic          ex_ld, mem_ld, wb_ld;

    logic          is_beq;
    logic          stall_a, stall_b;
    logic [1:0]    sel_a, sel_b;
    logic          stall_int;

    function automatic logic hit(input logic [RW-1:0] dst, input logic wr,
                                 input logic [RW-1:0] r);
        return wr && (dst == r) && (r != '0);
    endfunction

    // First matching rule wins; a stalled operand reports the register-file select.
    function automatic logic [2:0] resolve(input logic [RW-1:0] r);
        logic [2:0] res;
        if (hit(ex_dst, ex_wr, r))
            res = {1'b1, SEL_RF};
        else if (hit(mem_dst, mem_wr, r) && mem_ld)
            res = {1'b1, SEL_RF};
        else if (hit(mem_dst, mem_wr, r))
            res = {1'b0, SEL_EX};
        else if (hit(wb_dst, wb_wr, r))
            res = {1'b0, SEL_MEM};
        else
            res = {1'b0, SEL_RF};
        return res;
    endfunction

    assign is_beq = id_valid && (id_op == BEQ_OP);

    always_comb begin
        stall_a   = 1'b0;
        stall_b   = 1'b0;
        sel_a     = SEL_RF;
        sel_b     = SEL_RF;
        stall_int = 1'b0;
        if (is_beq) begin
            {stall_a, sel_a} = resolve(id_rs);
            {stall_b, sel_b} = resolve(id_rt);
            stall_int = stall_a | stall_b;
        end else if (id_valid) begin
            stall_int = ex_ld && (hit(ex_dst, ex_wr, id_rs) || hit(ex_dst, ex_wr, id_rt));
        end
    end

    // Outputs are forced inactive for as long as reset is held.
    assign stall = reset_n & stall_int;
    assign fa    = reset_n ? sel_a : SEL_RF;
    assign fb    = reset_n ? sel_b : SEL_RF;
    assign flush = reset_n & takebranch & is_beq & ~stall_int;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_dst  <= '0;
            ex_wr   <= 1'b0;
            ex_ld   <= 1'b0;
            mem_dst <= '0;
            mem_wr  <= 1'b0;
            mem_ld  <= 1'b0;
            wb_dst  <= '0;
            wb_wr   <= 1'b0;
            wb_ld   <= 1'b0;
        end else begin
            wb_dst  <= mem_dst;
            wb_wr   <= mem_wr;
            wb_ld   <= mem_ld;
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            mem_ld  <= ex_ld;
            if (stall_int || !id_valid) begin
                ex_dst <= '0;
                ex_wr  <= 1'b0;
                ex_ld  <= 1'b0;
            end else begin
                ex_dst <= id_dst;
                ex_wr  <= id_regwrite;
                ex_ld  <= id_memread;
            end
        end
    end

endmodule
